single_float_multiplier: RTL and testbench

SINGLE_FLOAT_MULTIPLIER -- requirements
Module: single_float_multiplier

---
 rtl/float_pkg.sv | 44 ++++
 rtl/float_mant_mult_seq.sv | 55 +++++
 rtl/single_float_multiplier.sv | 175 +++++++++++++++++
 tb/tb_single_float_multiplier.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared definitions for the single-precision float datapath blocks:
// default format constants, FSM state and operand-class encodings.
package float_pkg;

  localparam int FP_DWIDTH    = 32;
  localparam int FP_EXP_WIDTH = 8;
  localparam int FP_BIAS      = 127;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_INF  = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MULT   = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    DONE   = 3'd5
  } fsm_state_t;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fclass_t;

  // Width-independent classifier; denormals (exp==0, mant!=0) fold into zero.
  function automatic fclass_t classify(input logic exp_ones, input logic exp_zero,
                                       input logic mant_zero);
    fclass_t cls;
    if (exp_ones && !mant_zero) begin
      cls = CLS_NAN;
    end else if (exp_ones) begin
      cls = CLS_INF;
    end else if (exp_zero) begin
      cls = CLS_ZERO;
    end else begin
      cls = CLS_NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/float_mant_mult_seq.sv
// Iterative shift-add mantissa multiplier: one multiplier bit per cycle,
// MANT_W cycles after start; done flags the cycle of the final accumulation.
module float_mant_mult_seq #(
  parameter int MANT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [MANT_W-1:0]     mcand,
  input  logic [MANT_W-1:0]     mplier,
  output logic                  done,
  output logic [2*MANT_W-1:0]   product
);

  localparam int PW = 2 * MANT_W;
  localparam int CW = $clog2(MANT_W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MANT_W - 1);

  logic [PW-1:0]     mcand_r;
  logic [PW-1:0]     acc_r;
  logic [MANT_W-1:0] mplier_r;
  logic [CW-1:0]     cnt_r;
  logic              run_r;

  assign done    = run_r && (cnt_r == LAST_CNT);
  assign product = acc_r;

  // Load operands on start, then accumulate one partial product per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {PW{1'b0}};
      acc_r    <= {PW{1'b0}};
      mplier_r <= {MANT_W{1'b0}};
      cnt_r    <= {CW{1'b0}};
      run_r    <= 1'b0;
    end else if (start) begin
      mcand_r  <= {{MANT_W{1'b0}}, mcand};
      acc_r    <= {PW{1'b0}};
      mplier_r <= mplier;
      cnt_r    <= {CW{1'b0}};
      run_r    <= 1'b1;
    end else if (run_r) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CW'(1);
      if (done) begin
        run_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/single_float_multiplier.sv
// IEEE-754 multiplier with fixed 28-edge latency: unpack, iterative mantissa
// multiply, normalise, round-to-nearest-even, then pack with special cases.
module single_float_multiplier
  import float_pkg::*;
#(
  parameter int DWIDTH         = FP_DWIDTH,
  parameter int EXPONENT_WIDTH = FP_EXP_WIDTH,
  parameter int BIAS           = FP_BIAS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic              ip_ready,
  output logic [DWIDTH-1:0] product,
  output logic              valid,
  output logic              busy
);

  localparam int MW      = DWIDTH - EXPONENT_WIDTH - 1;
  localparam int MANT_W  = MW + 1;
  localparam int PW      = 2 * MANT_W;
  localparam int XW      = EXPONENT_WIDTH + 2;
  localparam int EXP_MAX = (1 << EXPONENT_WIDTH) - 1;

  fsm_state_t               state_r;
  logic [DWIDTH-1:0]        a_r, b_r;
  logic                     sign_r;
  logic [EXPONENT_WIDTH-1:0] ea_r, eb_r;
  fclass_t                  cls_a_r, cls_b_r;
  logic [XW-1:0]            exp_r;
  logic [MANT_W-1:0]        mant_r;
  logic                     guard_r, sticky_r;
  logic [DWIDTH-1:0]        product_r;
  logic                     valid_r, busy_r;

  logic                     mult_start_s, mult_done_s;
  logic [PW-1:0]            mprod_s;
  logic                     round_up_s;
  logic [MANT_W:0]          rsum_s;
  logic                     exp_ovf_s, exp_unf_s;
  logic                     any_nan_s, inf_x_zero_s, any_inf_s, any_zero_s;
  logic [DWIDTH-1:0]        result_s;

  assign product = product_r;
  assign valid   = valid_r;
  assign busy    = busy_r;

  assign mult_start_s = (state_r == UNPACK);

  float_mant_mult_seq #(
    .MANT_W (MANT_W)
  ) u_mant_mult (
    .clk     (clk),
    .rst_n   (rst),
    .start   (mult_start_s),
    .mcand   ({1'b1, a_r[MW-1:0]}),
    .mplier  ({1'b1, b_r[MW-1:0]}),
    .done    (mult_done_s),
    .product (mprod_s)
  );

  // Round-to-nearest-even increment on the normalised mantissa.
  always_comb begin
    round_up_s = guard_r & (sticky_r | mant_r[0]);
    rsum_s     = {1'b0, mant_r} + {{MANT_W{1'b0}}, round_up_s};
  end

  // Exponent is carried as two's complement with two headroom bits.
  always_comb begin
    exp_ovf_s = !exp_r[XW-1] && (exp_r >= XW'(EXP_MAX));
    exp_unf_s = exp_r[XW-1] || (exp_r == {XW{1'b0}});
  end

  // Final packing with special-case priority: NaN, inf, zero, then range.
  always_comb begin
    any_nan_s    = (cls_a_r == CLS_NAN) || (cls_b_r == CLS_NAN);
    inf_x_zero_s = ((cls_a_r == CLS_INF) && (cls_b_r == CLS_ZERO)) ||
                   ((cls_a_r == CLS_ZERO) && (cls_b_r == CLS_INF));
    any_inf_s    = (cls_a_r == CLS_INF) || (cls_b_r == CLS_INF);
    any_zero_s   = (cls_a_r == CLS_ZERO) || (cls_b_r == CLS_ZERO);
    if (any_nan_s || inf_x_zero_s) begin
      result_s = {1'b0, {EXPONENT_WIDTH{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    end else if (any_inf_s || exp_ovf_s) begin
      result_s = {sign_r, {EXPONENT_WIDTH{1'b1}}, {MW{1'b0}}};
    end else if (any_zero_s || exp_unf_s) begin
      result_s = {sign_r, {(DWIDTH-1){1'b0}}};
    end else begin
      result_s = {sign_r, exp_r[EXPONENT_WIDTH-1:0], mant_r[MW-1:0]};
    end
  end

  // Control FSM and datapath registers; every state but MULT lasts one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      a_r       <= {DWIDTH{1'b0}};
      b_r       <= {DWIDTH{1'b0}};
      sign_r    <= 1'b0;
      ea_r      <= {EXPONENT_WIDTH{1'b0}};
      eb_r      <= {EXPONENT_WIDTH{1'b0}};
      cls_a_r   <= CLS_ZERO;
      cls_b_r   <= CLS_ZERO;
      exp_r     <= {XW{1'b0}};
      mant_r    <= {MANT_W{1'b0}};
      guard_r   <= 1'b0;
      sticky_r  <= 1'b0;
      product_r <= {DWIDTH{1'b0}};
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ip_ready) begin
            a_r     <= a;
            b_r     <= b;
            busy_r  <= 1'b1;
            state_r <= UNPACK;
          end
        end
        UNPACK: begin
          sign_r  <= a_r[DWIDTH-1] ^ b_r[DWIDTH-1];
          ea_r    <= a_r[DWIDTH-2 -: EXPONENT_WIDTH];
          eb_r    <= b_r[DWIDTH-2 -: EXPONENT_WIDTH];
          cls_a_r <= classify(&a_r[DWIDTH-2 -: EXPONENT_WIDTH],
                              ~|a_r[DWIDTH-2 -: EXPONENT_WIDTH], ~|a_r[MW-1:0]);
          cls_b_r <= classify(&b_r[DWIDTH-2 -: EXPONENT_WIDTH],
                              ~|b_r[DWIDTH-2 -: EXPONENT_WIDTH], ~|b_r[MW-1:0]);
          state_r <= MULT;
        end
        MULT: begin
          exp_r <= XW'(ea_r) + XW'(eb_r) - XW'(BIAS);
          if (mult_done_s) begin
            state_r <= NORM;
          end
        end
        NORM: begin
          // Product of two [1,2) mantissas lies in [1,4); MSB set means >= 2.
          if (mprod_s[PW-1]) begin
            mant_r   <= mprod_s[PW-1 -: MANT_W];
            guard_r  <= mprod_s[PW-1-MANT_W];
            sticky_r <= |mprod_s[PW-2-MANT_W:0];
            exp_r    <= exp_r + XW'(1);
          end else begin
            mant_r   <= mprod_s[PW-2 -: MANT_W];
            guard_r  <= mprod_s[PW-2-MANT_W];
            sticky_r <= |mprod_s[PW-3-MANT_W:0];
          end
          state_r <= ROUND;
        end
        ROUND: begin
          if (rsum_s[MANT_W]) begin
            mant_r <= rsum_s[MANT_W:1];
            exp_r  <= exp_r + XW'(1);
          end else begin
            mant_r <= rsum_s[MANT_W-1:0];
          end
          state_r <= DONE;
        end
        DONE: begin
          product_r <= result_s;
          valid_r   <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_single_float_multiplier.sv
// Scoreboard bench: stimulus pushes expected products, a monitor pops and
// compares on every valid pulse, including the fixed 28-edge latency.
module tb_single_float_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        ip_ready = 1'b0;
  logic [31:0] product;
  logic        valid;
  logic        busy;

  typedef struct {
    string       name;
    logic [31:0] req;
    int          cap;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  single_float_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .ip_ready (ip_ready),
    .product  (product),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Wait for idle, present operands for one capture edge, log the expectation.
  task automatic issue(input string name, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ev, input bit push);
    int w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (busy !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_idle_wait: busy still %b after 200 cycles, required 0", name, busy);
    end
    a = av;
    b = bv;
    ip_ready = 1'b1;
    @(posedge clk);
    #1;
    ip_ready = 1'b0;
    check({name, "_busy_set"}, {31'b0, busy}, 32'h1);
    if (push) begin
      e.name = name;
      e.req  = ev;
      e.cap  = cyc;
      sbq.push_back(e);
    end
  endtask

  // Monitor: compare every valid pulse against the head of the scoreboard.
  initial begin
    bit   chk_next;
    exp_t e;
    chk_next = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_next) begin
        check({e.name, "_valid_width"}, {31'b0, valid}, 32'h0);
        chk_next = 1'b0;
      end
      if (rst && valid) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_valid: got product %h, required no result", product);
        end else begin
          e = sbq.pop_front();
          check(e.name, product, e.req);
          check({e.name, "_latency"}, 32'(cyc - e.cap), 32'd28);
          check({e.name, "_busy_clear"}, {31'b0, busy}, 32'h0);
          chk_next = 1'b1;
        end
      end
    end
  end

  initial begin
    int w;
    repeat (3) @(negedge clk);
    check("reset_product", product, 32'h0);
    check("reset_valid", {31'b0, valid}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    rst = 1'b1;

    issue("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b1);
    issue("mul_0p8xm0p5", 32'h3F4CCCCD, 32'hBF000000, 32'hBECCCCCD, 1'b1);
    issue("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1);
    issue("ninf_x_2", 32'hFF800000, 32'h40000000, 32'hFF800000, 1'b1);
    issue("nzero_x_1", 32'h80000000, 32'h3F800000, 32'h80000000, 1'b1);
    issue("overflow", 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1'b1);
    issue("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 1'b1);
    issue("nan_in", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b1);
    issue("tie_even", 32'h3FC00000, 32'h3F800001, 32'h3FC00002, 1'b1);
    issue("ulp_square", 32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b1);

    // Operand and request churn while the multiply is in flight.
    issue("ignore_churn", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b1);
    repeat (5) @(negedge clk);
    a = 32'h7F800000;
    b = 32'h00000000;
    for (int i = 0; i < 6; i++) begin
      ip_ready = ~ip_ready;
      a = a ^ 32'h0012_3456;
      @(negedge clk);
    end
    ip_ready = 1'b0;

    // Abort mid-MULT with reset, then re-run cleanly.
    issue("aborted", 32'h3FC00000, 32'h40000000, 32'h0, 1'b0);
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_product", product, 32'h0);
    check("abort_valid", {31'b0, valid}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    issue("after_abort", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b1);
    issue("mul_2x3", 32'h40000000, 32'h40400000, 32'h40C00000, 1'b1);

    w = 0;
    while (sbq.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (60) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
